dmem_responder: RTL and testbench

Memory-side responder for the pipeline's MEM-stage data accesses. It replaces the single-cycle data memory with a request/response handshake: it accepts one read or write request at a time, returns read data after a programmable latency, and drives a stall to freeze the pipeline while an access is outstanding. It holds a 32-word x 32-bit array indexed by address bits [4:0].

---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_if.sv | 35 +++
 rtl/dmem_array.sv | 54 +++++
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the MEM-stage data memory responder:
//   - state_t        : responder FSM states
//   - DEF_DEPTH/AW   : default array geometry (32 words, 5-bit word index)
//   - DEF_RD_LAT     : default read latency in cycles
//   - CNT_W          : width of the read latency counter (covers 1..15)
//   - PRELOAD_WORD0/1: values loaded into words 0 and 1 on reset
//   - preload_value(): reset contents for any word index
// ---------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam int DEF_DEPTH  = 32;
  localparam int DEF_AW     = 5;
  localparam int DEF_RD_LAT = 2;
  localparam int CNT_W      = 4;

  localparam logic [31:0] PRELOAD_WORD0 = 32'd5;
  localparam logic [31:0] PRELOAD_WORD1 = 32'd10;

  // Reset image of the array: everything clears to zero except the two
  // seeded words the boot code expects to find.
  function automatic logic [31:0] preload_value(input int idx);
    logic [31:0] val;
    val = 32'd0;
    if (idx == 0) val = PRELOAD_WORD0;
    if (idx == 1) val = PRELOAD_WORD1;
    return val;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// ---------------------------------------------------------------------------
// dmem_if
// Request/response bundle between the MEM stage (master) and the data
// memory responder (slave).
//   req_valid  : master presents an access, held until rsp_valid
//   req_write  : 1 = write, 0 = read
//   req_addr   : word address, only the low index bits are used
//   req_wdata  : write data
//   req_ready  : responder idle and able to accept
//   rsp_valid  : one-cycle completion pulse for reads and writes
//   rsp_rdata  : read data, zero for write completions
//   stall      : freeze the upstream pipeline registers
// ---------------------------------------------------------------------------
interface dmem_if;

  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, stall
  );

endinterface

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Word-addressed storage for the responder: one synchronous write port and
// one registered read port. Reset clears the array and seeds words 0 and 1.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : write wr_data into word wr_addr at the rising edge
//   wr_addr   : write word index
//   wr_data   : write data
//   rd_en     : load rd_data from word rd_addr at the rising edge
//   rd_addr   : read word index
//   rd_data   : registered read data, holds its value while rd_en is low
// ---------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  // Storage words. The reset image is built from the package so the
  // seeded values live in one place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= preload_value(i);
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read data register; it keeps the last read word until the next read
  // so the response bus stays stable between accesses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= 32'd0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for MEM-stage data accesses. Accepts one read or
// write at a time, answers writes after one cycle and reads after RD_LAT
// cycles, and stalls the pipeline while an access is outstanding.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : dmem_if slave side (request in, ready/response/stall out)
// Parameters:
//   DEPTH  : number of 32-bit words, equal to 2**AW
//   AW     : word index width taken from req_addr[AW-1:0]
//   RD_LAT : read acceptance to rsp_valid latency, 1..15
// ---------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AW     = DEF_AW,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LAT - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [AW-1:0]    addr_q, addr_next;
  logic             is_write, is_write_next;

  logic             wr_en;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [31:0]      rd_data;
  logic             req_ready;
  logic             rsp_valid;

  // Upper address bits are deliberately dropped so addresses alias modulo
  // the array size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.req_addr[31:AW];

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (bus.req_addr[AW-1:0]),
    .wr_data (bus.req_wdata),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // State, latency counter and captured request attributes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      is_write <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      addr_q   <= addr_next;
      is_write <= is_write_next;
    end
  end

  // Next-state and handshake decode. Writes commit to the array on the
  // accepting edge, so a later read always sees them. The read port fires
  // on the edge that enters RESP; with a one-cycle latency that is the
  // accepting edge itself, so the read index comes straight off the bus
  // while idle and from the captured index otherwise.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    addr_next     = addr_q;
    is_write_next = is_write;
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = addr_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;

    case (state)
      IDLE: begin
        req_ready = 1'b1;
        rd_addr   = bus.req_addr[AW-1:0];
        if (bus.req_valid) begin
          addr_next     = bus.req_addr[AW-1:0];
          is_write_next = bus.req_write;
          if (bus.req_write) begin
            wr_en      = 1'b1;
            state_next = RESP;
          end else begin
            cnt_next = LAT_M1;
            if (RD_LAT == 1) begin
              rd_en      = 1'b1;
              state_next = RESP;
            end else begin
              state_next = RD_WAIT;
            end
          end
        end
      end

      RD_WAIT: begin
        cnt_next = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          rd_en      = 1'b1;
          state_next = RESP;
        end
      end

      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Write completions report zero data; otherwise the read register is
  // shown as-is so the last read value is held between accesses.
  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = (state == RESP && is_write) ? 32'd0 : rd_data;
  assign bus.stall     = bus.req_valid & ~rsp_valid;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder: a main instance with RD_LAT=2 plus
// three instances with RD_LAT=1, 3 and 15 for the latency sweep. A small
// PC model advances whenever stall is low to show the pipeline freeze.
// ---------------------------------------------------------------------------
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dmem_if main_if ();
  dmem_if lat1_if ();
  dmem_if lat3_if ();
  dmem_if lat15_if ();

  dmem_responder #(.RD_LAT(2))  dut      (.clk(clk), .rst(rst), .bus(main_if));
  dmem_responder #(.RD_LAT(1))  dut_lat1 (.clk(clk), .rst(rst), .bus(lat1_if));
  dmem_responder #(.RD_LAT(3))  dut_lat3 (.clk(clk), .rst(rst), .bus(lat3_if));
  dmem_responder #(.RD_LAT(15)) dut_lat15(.clk(clk), .rst(rst), .bus(lat15_if));

  // Sweep instances all read word 0; only req_valid differs per instance.
  logic        sw_req  [3];
  logic        sw_rsp  [3];
  logic        sw_stl  [3];
  logic [31:0] sw_data [3];

  assign lat1_if.req_valid  = sw_req[0];
  assign lat3_if.req_valid  = sw_req[1];
  assign lat15_if.req_valid = sw_req[2];
  assign lat1_if.req_write  = 1'b0;
  assign lat3_if.req_write  = 1'b0;
  assign lat15_if.req_write = 1'b0;
  assign lat1_if.req_addr   = 32'd0;
  assign lat3_if.req_addr   = 32'd0;
  assign lat15_if.req_addr  = 32'd0;
  assign lat1_if.req_wdata  = 32'd0;
  assign lat3_if.req_wdata  = 32'd0;
  assign lat15_if.req_wdata = 32'd0;

  assign sw_rsp[0]  = lat1_if.rsp_valid;
  assign sw_rsp[1]  = lat3_if.rsp_valid;
  assign sw_rsp[2]  = lat15_if.rsp_valid;
  assign sw_stl[0]  = lat1_if.stall;
  assign sw_stl[1]  = lat3_if.stall;
  assign sw_stl[2]  = lat15_if.stall;
  assign sw_data[0] = lat1_if.rsp_rdata;
  assign sw_data[1] = lat3_if.rsp_rdata;
  assign sw_data[2] = lat15_if.rsp_rdata;

  // Toy program counter: frozen whenever the responder stalls.
  int pc;
  always @(posedge clk) begin
    if (rst) pc <= 0;
    else if (!main_if.stall) pc <= pc + 1;
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // One complete access on the main instance, starting from IDLE. Reports
  // cycles from acceptance to rsp_valid, stalled cycles, returned data and
  // how far the PC moved between the request cycle and the response cycle.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, output int lat,
                               output int stalls, output logic [31:0] rdata,
                               output int pc_delta);
    int pc_start;
    @(posedge clk);
    #1;
    main_if.req_valid = 1'b1;
    main_if.req_write = wr;
    main_if.req_addr  = addr;
    main_if.req_wdata = wdata;
    lat      = -1;
    stalls   = 0;
    rdata    = 32'hFFFF_FFFF;
    pc_start = 0;
    pc_delta = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (cyc == 0) pc_start = pc;
      if (main_if.stall) stalls++;
      if (main_if.rsp_valid) begin
        lat      = cyc;
        rdata    = main_if.rsp_rdata;
        pc_delta = pc - pc_start;
        break;
      end
    end
    if (lat < 0) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL access_timeout observed=no_rsp expected=rsp_valid");
    end
    @(posedge clk);
    #1;
    main_if.req_valid = 1'b0;
  endtask

  initial begin
    int          lat, stalls, pc_delta;
    logic [31:0] rdata, r1, r2;
    int          sw_lat   [3];
    int          sw_stalls[3];
    logic [31:0] sw_rd    [3];
    logic        sw_done  [3];
    int          exp_lat  [3];

    exp_lat[0] = 1;
    exp_lat[1] = 3;
    exp_lat[2] = 15;

    rst = 1'b1;
    main_if.req_valid = 1'b0;
    main_if.req_write = 1'b0;
    main_if.req_addr  = 32'd0;
    main_if.req_wdata = 32'd0;
    for (int i = 0; i < 3; i++) sw_req[i] = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_rsp_valid", 32'(main_if.rsp_valid), 32'd0);
    checkOutput("reset_req_ready", 32'(main_if.req_ready), 32'd1);
    checkOutput("reset_rsp_rdata", main_if.rsp_rdata, 32'd0);
    checkOutput("reset_stall_low", 32'(main_if.stall), 32'd0);
    main_if.req_valid = 1'b1;
    #1;
    checkOutput("reset_stall_follows", 32'(main_if.stall), 32'd1);
    main_if.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released");

    // Pipeline hookup: lw r2 <- [1], lw r1 <- [0], add r3 = r1 + r2
    applyStimulus(1'b0, 32'd1, 32'd0, lat, stalls, r2, pc_delta);
    checkOutput("lw1_latency", 32'(lat), 32'd2);
    checkOutput("lw1_data", r2, 32'd10);
    applyStimulus(1'b0, 32'd0, 32'd0, lat, stalls, r1, pc_delta);
    checkOutput("lw0_data", r1, 32'd5);
    checkOutput("lw0_stalls", 32'(stalls), 32'd2);
    checkOutput("lw0_pc_held", 32'(pc_delta), 32'd0);
    checkOutput("add_result", r1 + r2, 32'd15);

    // Write then read back
    applyStimulus(1'b1, 32'd7, 32'hDEAD_BEEF, lat, stalls, rdata, pc_delta);
    checkOutput("wr7_latency", 32'(lat), 32'd1);
    checkOutput("wr7_stalls", 32'(stalls), 32'd1);
    checkOutput("wr7_rdata_zero", rdata, 32'd0);
    applyStimulus(1'b0, 32'd7, 32'd0, lat, stalls, rdata, pc_delta);
    checkOutput("rd7_latency", 32'(lat), 32'd2);
    checkOutput("rd7_stalls", 32'(stalls), 32'd2);
    checkOutput("rd7_data", rdata, 32'hDEAD_BEEF);

    // Address alias: 0x20 lands on word 0
    applyStimulus(1'b1, 32'h20, 32'h1234, lat, stalls, rdata, pc_delta);
    checkOutput("wr20_latency", 32'(lat), 32'd1);
    applyStimulus(1'b0, 32'd0, 32'd0, lat, stalls, rdata, pc_delta);
    checkOutput("alias_rd0_data", rdata, 32'h1234);

    // Request held through RD_WAIT/RESP is only re-accepted once IDLE
    @(posedge clk);
    #1;
    main_if.req_valid = 1'b1;
    main_if.req_write = 1'b0;
    main_if.req_addr  = 32'd0;
    @(negedge clk);
    checkOutput("hold_c0_ready", 32'(main_if.req_ready), 32'd1);
    @(negedge clk);
    checkOutput("hold_wait_ready", 32'(main_if.req_ready), 32'd0);
    checkOutput("hold_wait_rsp", 32'(main_if.rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("hold_resp_rsp", 32'(main_if.rsp_valid), 32'd1);
    checkOutput("hold_resp_data", main_if.rsp_rdata, 32'h1234);
    checkOutput("hold_resp_ready", 32'(main_if.req_ready), 32'd0);
    checkOutput("hold_resp_stall", 32'(main_if.stall), 32'd0);
    @(posedge clk);
    #1;
    main_if.req_addr = 32'd1;
    @(negedge clk);
    checkOutput("hold_idle_rsp", 32'(main_if.rsp_valid), 32'd0);
    checkOutput("hold_idle_ready", 32'(main_if.req_ready), 32'd1);
    checkOutput("hold_idle_stall", 32'(main_if.stall), 32'd1);
    @(negedge clk);
    checkOutput("hold_2nd_wait_rsp", 32'(main_if.rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("hold_2nd_rsp", 32'(main_if.rsp_valid), 32'd1);
    checkOutput("hold_2nd_data", main_if.rsp_rdata, 32'd10);
    @(posedge clk);
    #1;
    main_if.req_valid = 1'b0;

    // Reset in the middle of a read
    @(posedge clk);
    #1;
    main_if.req_valid = 1'b1;
    main_if.req_write = 1'b0;
    main_if.req_addr  = 32'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_rsp_valid", 32'(main_if.rsp_valid), 32'd0);
    checkOutput("midrst_req_ready", 32'(main_if.req_ready), 32'd1);
    checkOutput("midrst_rdata", main_if.rsp_rdata, 32'd0);
    main_if.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_no_rsp", 32'(main_if.rsp_valid), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 32'd7, 32'd0, lat, stalls, rdata, pc_delta);
    checkOutput("postrst_rd7_data", rdata, 32'd0);
    applyStimulus(1'b0, 32'd1, 32'd0, lat, stalls, rdata, pc_delta);
    checkOutput("postrst_rd1_latency", 32'(lat), 32'd2);
    checkOutput("postrst_rd1_data", rdata, 32'd10);

    // Latency sweep on the RD_LAT=1/3/15 instances, all reading word 0
    for (int i = 0; i < 3; i++) begin
      sw_lat[i]    = -1;
      sw_stalls[i] = 0;
      sw_rd[i]     = 32'hFFFF_FFFF;
      sw_done[i]   = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) sw_req[i] = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (!sw_done[i]) begin
          if (sw_stl[i]) sw_stalls[i]++;
          if (sw_rsp[i]) begin
            sw_lat[i]  = cyc;
            sw_rd[i]   = sw_data[i];
            sw_done[i] = 1'b1;
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (sw_done[i]) sw_req[i] = 1'b0;
      end
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("sweep%0d_latency", exp_lat[i]), 32'(sw_lat[i]), 32'(exp_lat[i]));
      checkOutput($sformatf("sweep%0d_stalls", exp_lat[i]), 32'(sw_stalls[i]), 32'(exp_lat[i]));
      checkOutput($sformatf("sweep%0d_data", exp_lat[i]), sw_rd[i], 32'd5);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
